// File: rtl/pipelined_handshake_divider.sv
// Iterative signed/unsigned integer divider, one quotient bit per cycle, with
// valid/ready handshakes on both sides, result backpressure and cancel/flush.
module pipelined_handshake_divider #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  request_valid,
  output logic                  request_ready,
  input  logic                  is_signed_input,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  cancel,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  divide_by_zero,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;
  localparam logic [COUNT_WIDTH-1:0] LAST_ITER = COUNT_WIDTH'(DATA_WIDTH - 1);

  state_t                 state;
  logic [COUNT_WIDTH-1:0] count;
  logic [DATA_WIDTH:0]    part_rem;
  logic [DATA_WIDTH-1:0]  quo_acc, dvsr_mag;
  logic                   q_neg, r_neg, dvsr_zero;

  logic                   accept, dvd_neg, dvs_neg;
  logic [DATA_WIDTH:0]    dvsr_ext, shifted, stepped;
  logic [DATA_WIDTH-1:0]  rem_fix, quo_final, rem_final;

  assign request_ready = reset_n && (state == IDLE) && !cancel;
  assign accept        = request_valid && request_ready;
  assign busy          = (state != IDLE);
  assign dvd_neg       = is_signed_input && dividend[DATA_WIDTH-1];
  assign dvs_neg       = is_signed_input && divisor[DATA_WIDTH-1];

  // Non-restoring step: quo_acc shifts dividend bits into the partial remainder
  // from the top while quotient bits fill in from the bottom. The W+1 bit
  // partial remainder wraps modulo 2^(W+1), which still lands in [-D, D).
  assign dvsr_ext = {1'b0, dvsr_mag};
  assign shifted  = {part_rem[DATA_WIDTH-1:0], quo_acc[DATA_WIDTH-1]};
  assign stepped  = part_rem[DATA_WIDTH] ? shifted + dvsr_ext : shifted - dvsr_ext;

  // Divide-by-zero leaves the dividend magnitude in part_rem, so the sign rule
  // alone restores the original dividend as the remainder.
  assign rem_fix   = part_rem[DATA_WIDTH-1:0] + (part_rem[DATA_WIDTH] ? dvsr_mag : '0);
  assign quo_final = dvsr_zero ? '1 : (q_neg ? -quo_acc : quo_acc);
  assign rem_final = r_neg ? -rem_fix : rem_fix;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= IDLE;
      count          <= '0;
      part_rem       <= '0;
      quo_acc        <= '0;
      dvsr_mag       <= '0;
      q_neg          <= 1'b0;
      r_neg          <= 1'b0;
      dvsr_zero      <= 1'b0;
      result_valid   <= 1'b0;
      quotient       <= '0;
      remainder      <= '0;
      divide_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          state     <= DIVIDE;
          count     <= '0;
          part_rem  <= '0;
          quo_acc   <= dvd_neg ? -dividend : dividend;
          dvsr_mag  <= dvs_neg ? -divisor : divisor;
          q_neg     <= dvd_neg ^ dvs_neg;
          r_neg     <= dvd_neg;
          dvsr_zero <= (divisor == '0);
        end
        DIVIDE: if (cancel) begin
          state <= IDLE;
        end else begin
          part_rem <= stepped;
          quo_acc  <= {quo_acc[DATA_WIDTH-2:0], ~stepped[DATA_WIDTH]};
          count    <= count + COUNT_WIDTH'(1);
          if (count == LAST_ITER) state <= FIXUP;
        end
        FIXUP: if (cancel) begin
          state <= IDLE;
        end else begin
          quotient       <= quo_final;
          remainder      <= rem_final;
          divide_by_zero <= dvsr_zero;
          state          <= DONE;
        end
        // First DONE cycle raises result_valid; it then holds until taken or flushed.
        DONE: if (cancel || (result_valid && result_ready)) begin
          state        <= IDLE;
          result_valid <= 1'b0;
        end else begin
          result_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipelined_handshake_divider.sv
// Randomised + directed bench for three divider widths against a cycle-level
// behavioural model built from plain integer division.
module tb_pipelined_handshake_divider;
  typedef struct packed {
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
  } res_t;

  logic clock;
  int   n_tests = 0;
  int   n_fail  = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input int w, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL w%0d %s: got %0h expected %0h", w, nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input int w, input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL w%0d %s: wait bound expired", w, nm);
  endtask

  function automatic longint sext(input logic [63:0] v, input int w);
    longint t;
    t = longint'(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  // Reference: truncating division, remainder follows dividend, div-by-zero convention.
  function automatic res_t ref_div(input int w, input bit s, input logic [63:0] a, input logic [63:0] b);
    res_t r;
    logic [63:0] m;
    longint sa, sb;
    m     = (64'd1 << w) - 64'd1;
    r.dbz = (b == 64'd0);
    if (r.dbz) begin
      r.q = m;
      r.r = a;
    end else if (s) begin
      sa  = sext(a, w);
      sb  = sext(b, w);
      r.q = 64'(sa / sb) & m;
      r.r = 64'(sa % sb) & m;
    end else begin
      r.q = a / b;
      r.r = a % b;
    end
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int W = (g == 0) ? 32 : (g == 1) ? 16 : 8;

    logic         rst_n, req_valid, req_ready, sgn, cancel;
    logic         res_valid, res_ready, dbz, busy;
    logic [W-1:0] dvd, dvs, quo, rem;

    bit   alive = 1'b0;
    int   n     = 0;
    res_t exp_r, out_r;
    bit   done  = 1'b0;

    pipelined_handshake_divider #(.DATA_WIDTH(W)) dut (
      .clock(clock), .reset_n(rst_n),
      .request_valid(req_valid), .request_ready(req_ready),
      .is_signed_input(sgn), .dividend(dvd), .divisor(dvs), .cancel(cancel),
      .result_valid(res_valid), .result_ready(res_ready),
      .quotient(quo), .remainder(rem), .divide_by_zero(dbz), .busy(busy)
    );

    // Model: an accepted op lives W+2 edges before its result shows, outputs
    // are loaded at edge W+1; cancel or reset drops it.
    initial forever begin
      @(posedge clock);
      if (!rst_n) begin
        alive = 1'b0;
        n     = 0;
        out_r = '0;
      end else if (alive) begin
        if (cancel) alive = 1'b0;
        else if (n >= W + 2) begin
          if (res_ready) alive = 1'b0;
        end else begin
          n++;
          if (n == W + 1) out_r = exp_r;
        end
      end else if (req_valid && !cancel) begin
        alive = 1'b1;
        n     = 0;
        exp_r = ref_div(W, sgn, 64'(dvd), 64'(dvs));
      end
    end

    initial forever begin
      @(negedge clock);
      #1;
      chk(W, "result_valid", res_valid, alive && (n >= W + 2));
      chk(W, "busy", busy, alive);
      chk(W, "request_ready", req_ready, rst_n && !alive && !cancel);
      chk(W, "quotient", quo, out_r.q);
      chk(W, "remainder", rem, out_r.r);
      chk(W, "divide_by_zero", dbz, out_r.dbz);
    end

    task automatic wait_ready();
      int k = 0;
      while (!req_ready && k < 200) begin
        @(negedge clock);
        k++;
      end
      if (!req_ready) timeout_fail(W, "request_ready_wait");
    endtask

    // cxl>0: pulse cancel so it is sampled on the cxl-th edge after accept.
    task automatic op(input bit s, input logic [63:0] a, input logic [63:0] b, input int bp, input int cxl);
      int k = 0;
      wait_ready();
      sgn = s; dvd = W'(a); dvs = W'(b); req_valid = 1'b1;
      @(negedge clock);
      req_valid = 1'b0; dvd = W'($urandom); dvs = W'($urandom); sgn = 1'($urandom);
      if (cxl > 0) begin
        repeat (cxl - 1) @(negedge clock);
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
      end else begin
        while (!res_valid && k < W + 10) begin
          @(negedge clock);
          k++;
        end
        if (!res_valid) begin
          timeout_fail(W, "result_valid_wait");
          rst_n = 1'b0;
          @(negedge clock);
          rst_n = 1'b1;
        end else begin
          repeat (bp) @(negedge clock);
          res_ready = 1'b1;
          @(negedge clock);
          res_ready = 1'b0;
        end
      end
    endtask

    initial begin
      logic [W-1:0] ra, rb;
      int kind, bp, cx;
      rst_n = 1'b0; req_valid = 1'b0; sgn = 1'b0; dvd = '0; dvs = '0;
      cancel = 1'b0; res_ready = 1'b0;
      repeat (2) @(negedge clock);
      rst_n = 1'b1;

      op(0, 100, 7, 0, 0);
      op(1, -7, 2, 0, 0);
      op(1, 7, -2, 0, 0);
      op(0, -7, 2, 0, 0);
      op(0, 5, 0, 0, 0);
      op(1, -5, 0, 0, 0);
      op(1, 64'd1 << (W - 1), -1, 0, 0);
      op(1, -128, 3, 0, 0);
      op(0, 1000, 3, 10, 0);
      op(0, 99, 9, 0, 0);
      op(0, 77, 5, 0, 10);
      op(0, 12, 5, 0, 0);
      op(1, -50, 7, 0, W + 1);
      op(1, -50, 7, 0, W + 5);

      // cancel together with a request in IDLE must not start an op
      wait_ready();
      cancel = 1'b1; req_valid = 1'b1; dvd = W'(3); dvs = W'(1);
      @(negedge clock);
      cancel = 1'b0; req_valid = 1'b0;
      repeat (2) @(negedge clock);

      // reset in the middle of DIVIDE
      wait_ready();
      sgn = 1'b0; dvd = W'(200); dvs = W'(6); req_valid = 1'b1;
      @(negedge clock);
      req_valid = 1'b0;
      repeat (4) @(negedge clock);
      rst_n = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
      op(0, 12, 5, 0, 0);

      repeat (120) begin
        kind = $urandom_range(0, 9);
        ra   = W'({$urandom, $urandom});
        rb   = W'({$urandom, $urandom});
        rb   = rb >> $urandom_range(0, W - 1);
        bp   = $urandom_range(0, 3);
        cx   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, W + 5) : 0;
        case (kind)
          0:       op(1'($urandom), 64'(ra), 0, bp, cx);
          1:       op(1, 64'd1 << (W - 1), -1, bp, cx);
          2:       op(1'($urandom), 64'(ra), $urandom_range(1, 7), bp, cx);
          default: op(1'($urandom), 64'(ra), 64'(rb), bp, cx);
        endcase
      end
      repeat (3) @(negedge clock);
      done = 1'b1;
    end
  end

  initial begin
    res_t r;
    int   cyc = 0;
    r = ref_div(32, 0, 100, 7);
    chk(32, "pin_100_7_q", r.q, 64'd14);
    chk(32, "pin_100_7_r", r.r, 64'd2);
    r = ref_div(32, 1, 64'hFFFF_FFF9, 2);
    chk(32, "pin_m7_2_q", r.q, 64'hFFFF_FFFD);
    chk(32, "pin_m7_2_r", r.r, 64'hFFFF_FFFF);
    r = ref_div(32, 1, 7, 64'hFFFF_FFFE);
    chk(32, "pin_7_m2_q", r.q, 64'hFFFF_FFFD);
    chk(32, "pin_7_m2_r", r.r, 64'd1);
    r = ref_div(32, 0, 64'hFFFF_FFF9, 2);
    chk(32, "pin_u_q", r.q, 64'h7FFF_FFFC);
    chk(32, "pin_u_r", r.r, 64'd1);
    r = ref_div(32, 0, 5, 0);
    chk(32, "pin_dbz_q", r.q, 64'hFFFF_FFFF);
    chk(32, "pin_dbz_r", r.r, 64'd5);
    chk(32, "pin_dbz_f", r.dbz, 64'd1);
    r = ref_div(32, 1, 64'h8000_0000, 64'hFFFF_FFFF);
    chk(32, "pin_ovf_q", r.q, 64'h8000_0000);
    chk(32, "pin_ovf_r", r.r, 64'd0);
    chk(32, "pin_ovf_f", r.dbz, 64'd0);
    r = ref_div(32, 0, 12, 5);
    chk(32, "pin_12_5_q", r.q, 64'd2);
    chk(32, "pin_12_5_r", r.r, 64'd2);
    r = ref_div(8, 1, 64'h80, 3);
    chk(8, "pin_w8_q", r.q, 64'hD6);
    chk(8, "pin_w8_r", r.r, 64'hFE);

    while (!(lane[0].done && lane[1].done && lane[2].done) && cyc < 60000) begin
      @(negedge clock);
      cyc++;
    end
    if (!(lane[0].done && lane[1].done && lane[2].done)) timeout_fail(0, "global_run");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
